// File: rtl/picomips_pkg.sv
// Shared types and constants for the picoMIPS register-file write path.
package picomips_pkg;

  typedef logic [4:0] regaddr_t;

  typedef enum logic [1:0] {IDLE, PEND, FORCE, DONE} ldstate_t;

  // Bit positions of the control switches inside SW[9:0]
  localparam int SW_LOAD    = 8;
  localparam int SW_RESTART = 9;

endpackage

// File: rtl/sw_sync.sv
// Two-flop synchroniser for asynchronous board switches, plus a third flop
// holding the previous synchronised value for rising-edge detection.
module sw_sync #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         nReset,
  input  logic [W-1:0] async_i,
  output logic [W-1:0] sync_o,
  output logic [W-1:0] rise_o
);

  logic [W-1:0] s1_q, s2_q, s3_q;

  // Synchroniser chain; s3 is the one-cycle-old copy of s2
  always_ff @(posedge clk) begin
    if (!nReset) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= async_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign sync_o = s2_q;
  assign rise_o = s2_q & ~s3_q;

endmodule

// File: rtl/regfile_load_arbiter.sv
// Owns the single register-file write port.  Shares it between the CPU
// writeback path and a switch-driven operand loader that fills COUNT
// consecutive registers starting at BASE, one per SW[8] press.
module regfile_load_arbiter
  import picomips_pkg::*;
#(
  parameter int       n       = 8,
  parameter regaddr_t BASE    = 5'd1,
  parameter int       COUNT   = 9,
  parameter int       MAXWAIT = 4
) (
  input  logic           clk,
  input  logic           nReset,
  input  logic           cpu_w,
  input  regaddr_t       cpu_waddr,
  input  logic [n-1:0]   cpu_wdata,
  input  logic [9:0]     SW,
  output logic           cpu_stall,
  output logic           rf_w,
  output regaddr_t       rf_waddr,
  output logic [n-1:0]   rf_wdata,
  output regaddr_t       load_idx,
  output logic           load_done,
  output logic           overrun
);

  localparam int       WW   = $clog2(MAXWAIT + 1);
  // One past the last loader destination; 6 bits so BASE+COUNT = 32 fits
  localparam logic [5:0] LAST = {1'b0, BASE} + 6'(COUNT);

  ldstate_t        state_q, state_d;
  logic [n-1:0]    pend_q, pend_d;
  regaddr_t        idx_q, idx_d;
  logic [WW-1:0]   wait_q, wait_d;
  logic            ovr_q, ovr_d;
  logic            ld_gnt;

  logic [9:0]      sw_s, sw_rise;
  logic            strobe, restart;
  logic            unused_sw;

  sw_sync #(.W(10)) u_sync (
    .clk    (clk),
    .nReset (nReset),
    .async_i(SW),
    .sync_o (sw_s),
    .rise_o (sw_rise)
  );

  assign strobe    = sw_rise[SW_LOAD];
  assign restart   = sw_rise[SW_RESTART];
  assign unused_sw = ^{sw_s[9:8], sw_rise[7:0]};

  // Loader FSM: next state, grant decision and loader bookkeeping
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    idx_d   = idx_q;
    wait_d  = wait_q;
    ovr_d   = ovr_q;
    ld_gnt  = 1'b0;
    if (restart) begin
      // Restart beats any strobe or grant this cycle; pending value is dropped
      state_d = IDLE;
      idx_d   = BASE;
      ovr_d   = 1'b0;
      wait_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (strobe) begin
            pend_d  = n'(sw_s[7:0]);
            wait_d  = '0;
            state_d = PEND;
          end
        end
        PEND, FORCE: begin
          if (strobe) ovr_d = 1'b1;
          if (state_q == FORCE || !cpu_w) begin
            ld_gnt  = 1'b1;
            idx_d   = idx_q + 5'd1;
            state_d = (({1'b0, idx_q} + 6'd1) == LAST) ? DONE : IDLE;
          end else begin
            wait_d = wait_q + WW'(1);
            if (wait_q == WW'(MAXWAIT - 1)) state_d = FORCE;
          end
        end
        DONE:    ;
        default: state_d = IDLE;
      endcase
    end
  end

  // Loader state registers
  always_ff @(posedge clk) begin
    if (!nReset) begin
      state_q <= IDLE;
      pend_q  <= '0;
      idx_q   <= BASE;
      wait_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      idx_q   <= idx_d;
      wait_q  <= wait_d;
      ovr_q   <= ovr_d;
    end
  end

  // Write-port mux: loader when granted, otherwise CPU pass-through
  always_comb begin
    rf_w     = cpu_w;
    rf_waddr = cpu_waddr;
    rf_wdata = cpu_wdata;
    if (ld_gnt) begin
      rf_w     = 1'b1;
      rf_waddr = idx_q;
      rf_wdata = pend_q;
    end
  end

  assign cpu_stall = (state_q == FORCE);
  assign load_done = (state_q == DONE);
  assign load_idx  = idx_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_regfile_load_arbiter.sv
// Scoreboard bench: the driver runs an abstract loader model each cycle and
// queues the expected port outputs; a monitor pops and compares them.
module tb_regfile_load_arbiter;
  import picomips_pkg::*;

  localparam int N = 8, BASE = 1, COUNT = 9, MAXWAIT = 4;

  logic       clk = 1'b0, nReset = 1'b0, cpu_w = 1'b0;
  logic [4:0] cpu_waddr = '0;
  logic [7:0] cpu_wdata = '0;
  logic [9:0] SW = '0;
  logic       cpu_stall, rf_w, load_done, overrun;
  logic [4:0] rf_waddr, load_idx;
  logic [7:0] rf_wdata;

  regfile_load_arbiter #(.n(N), .BASE(5'(BASE)), .COUNT(COUNT), .MAXWAIT(MAXWAIT)) dut (
    .clk(clk), .nReset(nReset), .cpu_w(cpu_w), .cpu_waddr(cpu_waddr),
    .cpu_wdata(cpu_wdata), .SW(SW), .cpu_stall(cpu_stall), .rf_w(rf_w),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .load_idx(load_idx),
    .load_done(load_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic w; logic [4:0] a; logic [7:0] d;
    logic stall, done, ovr; logic [4:0] idx;
  } exp_t;

  exp_t q[$];
  int   checks = 0, failures = 0;

  // Abstract loader model: a pending value, how many cycles it has lost,
  // whether it is now being forced, and how many registers are filled.
  bit         m_pend, m_force, m_done, m_ovr;
  int         m_idx, m_loss;
  logic [7:0] m_val;
  logic [9:0] h1, h2, h3;            // SW as applied 1, 2, 3 cycles ago
  bit         armed, last_stall;
  logic       hw;
  logic [4:0] ha;
  logic [7:0] hd;

  task automatic model_reset();
    m_pend = 0; m_force = 0; m_done = 0; m_ovr = 0;
    m_idx = BASE; m_loss = 0; m_val = '0;
    h1 = '0; h2 = '0; h3 = '0;
  endtask

  task automatic cyc(input logic rst_n, input logic w, input logic [4:0] a,
                     input logic [7:0] d, input logic [9:0] sw);
    exp_t e;
    bit strobe, restart, lg;
    @(negedge clk);
    // A stalled CPU write is re-presented unchanged
    if (last_stall && hw) begin w = hw; a = ha; d = hd; end
    nReset = rst_n; cpu_w = w; cpu_waddr = a; cpu_wdata = d; SW = sw;
    hw = w; ha = a; hd = d;
    strobe  = h2[SW_LOAD] & ~h3[SW_LOAD];
    restart = h2[SW_RESTART] & ~h3[SW_RESTART];
    lg = !restart && m_pend && (m_force || !w);
    e.w = lg ? 1'b1 : w;
    e.a = lg ? 5'(m_idx) : a;
    e.d = lg ? m_val : d;
    e.stall = m_force; e.done = m_done; e.ovr = m_ovr; e.idx = 5'(m_idx);
    if (armed) q.push_back(e);
    last_stall = m_force;
    if (!rst_n) model_reset();
    else begin
      if (restart) begin
        m_idx = BASE; m_ovr = 0; m_pend = 0; m_force = 0; m_loss = 0; m_done = 0;
      end else if (m_done) begin
        // strobes ignored until restart
      end else if (m_pend) begin
        if (strobe) m_ovr = 1;
        if (lg) begin
          m_idx++; m_pend = 0; m_force = 0;
          m_done = (m_idx == BASE + COUNT);
        end else begin
          m_loss++;
          if (m_loss == MAXWAIT) m_force = 1;
        end
      end else if (strobe) begin
        m_pend = 1; m_val = h2[7:0]; m_loss = 0;
      end
      h3 = h2; h2 = h1; h1 = sw;
    end
  endtask

  task automatic press(input logic [7:0] v);
    repeat (3) cyc(1, 0, 0, 0, {2'b01, v});
    repeat (3) cyc(1, 0, 0, 0, {2'b00, v});
  endtask

  task automatic do_restart();
    repeat (2) cyc(1, 0, 0, 0, 10'h200);
    repeat (3) cyc(1, 0, 0, 0, 10'h000);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare DUT outputs against the queued expectation each cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk); #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("rf_w", 32'(rf_w), 32'(e.w));
        if (e.w) begin
          chk("rf_waddr", 32'(rf_waddr), 32'(e.a));
          chk("rf_wdata", 32'(rf_wdata), 32'(e.d));
        end
        chk("cpu_stall", 32'(cpu_stall), 32'(e.stall));
        chk("load_done", 32'(load_done), 32'(e.done));
        chk("overrun",   32'(overrun),   32'(e.ovr));
        chk("load_idx",  32'(load_idx),  32'(e.idx));
      end
    end
  end

  initial begin
    logic [9:0] swr;
    logic [7:0] v;
    model_reset();
    armed = 0; last_stall = 0; hw = 0; ha = '0; hd = '0;
    repeat (2) cyc(0, 0, 0, 0, 0);
    armed = 1;
    repeat (3) cyc(1, 0, 0, 0, 0);

    // Single strobe with an idle CPU
    press(8'h5A);
    repeat (2) cyc(1, 0, 0, 0, 0);

    // Contention: CPU keeps writing reg 7 while the loader waits
    do_restart();
    repeat (3)  cyc(1, 1, 5'd7, 8'h33, 10'h1C3);
    repeat (10) cyc(1, 1, 5'd7, 8'h33, 10'h0C3);
    repeat (3)  cyc(1, 0, 0, 0, 0);

    // Overrun: second strobe while the first is still pending
    do_restart();
    cyc(1, 1, 5'd4, 8'h44, 10'h111);
    cyc(1, 1, 5'd4, 8'h44, 10'h022);
    cyc(1, 1, 5'd4, 8'h44, 10'h122);
    repeat (10) cyc(1, 1, 5'd4, 8'h44, 10'h022);
    repeat (3)  cyc(1, 0, 0, 0, 0);

    // Restart after three loads; next value lands at BASE
    do_restart();
    press(8'hA1); press(8'hA2); press(8'hA3);
    do_restart();
    press(8'hB7);

    // Full sequence 1..9 then a tenth strobe that must be ignored
    do_restart();
    for (int i = 1; i <= COUNT; i++) press(8'(i));
    press(8'hEE);

    // Restart and strobe arriving in the same cycle
    do_restart();
    repeat (3) cyc(1, 0, 0, 0, 10'h3C4);
    repeat (4) cyc(1, 0, 0, 0, 10'h000);

    // Reset while a load is forced
    do_restart();
    repeat (3) cyc(1, 1, 5'd9, 8'h99, 10'h155);
    repeat (6) cyc(1, 1, 5'd9, 8'h99, 10'h055);
    cyc(0, 0, 0, 0, 0);
    repeat (3) cyc(1, 0, 0, 0, 0);

    // Random traffic
    swr = '0;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0)  swr[SW_LOAD] = ~swr[SW_LOAD];
      if ($urandom_range(0, 59) == 0) swr[SW_RESTART] = ~swr[SW_RESTART];
      if ($urandom_range(0, 5) == 0) begin
        v = 8'($urandom);
        swr[7:0] = v;
      end
      cyc(($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1,
          1'($urandom_range(0, 1)), 5'($urandom), 8'($urandom), swr);
    end
    repeat (3) cyc(1, 0, 0, 0, 0);

    @(negedge clk); #4;
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_load_arbiter.md
# regfile_load_arbiter

Write-port arbiter and operand-load sequencer for the picoMIPS 32 x n register file. It owns the file's single write port and shares it between the CPU writeback path and a switch-driven loader. The loader deposits operands entered on SW[7:0] into consecutive registers, one per press of SW[8]. It sits between the core's writeback stage, the board switches and `regs`. Once it is in place, the file's SW-driven second write path is removed.

## Interface
Parameters:
- `n`, 8: data width.
- `BASE`, 5'd1: first loader destination. Must be ≥ 1.
- `COUNT`, 9: number of loader writes per sequence, 1..31. BASE+COUNT-1 ≤ 31.
- `MAXWAIT`, 4: cycles a loader write may wait behind CPU writes before it is forced.

Ports:
- `clk` in 1: single clock, rising edge.
- `nReset` in 1: synchronous, active-low reset, sampled on rising `clk`.
- `cpu_w` in 1: CPU write request.
- `cpu_waddr` in 5: CPU destination register.
- `cpu_wdata` in n: CPU write data.
- `SW` in 10: board switches, asynchronous.
  - SW[7:0]: operand value.
  - SW[8]: load strobe (rising edge).
  - SW[9]: restart (rising edge).
- `cpu_stall` out 1: CPU must hold its write and its pipeline this cycle.
- `rf_w` out 1: write enable to `regs`.
- `rf_waddr` out 5: write address to `regs`.
- `rf_wdata` out n: write data to `regs`.
- `load_idx` out 5: next loader destination.
- `load_done` out 1: all COUNT operands written.
- `overrun` out 1: sticky; a strobe arrived while a write was pending.

## Operation
- **Synchronisation.** SW[9:0] passes through two flops (s1, s2). A third flop (s3) holds the previous s2. A strobe is `s2[8] & ~s3[8]`; a restart is `s2[9] & ~s3[9]`.
- **Registered state.** `state`, `pend_data[n-1:0]`, `load_idx`, `wait_cnt[$clog2(MAXWAIT+1)-1:0]`, `overrun`.
- **IDLE.**
  - Strobe: `pend_data` ← s2[7:0], go to PEND, `wait_cnt` ← 0.
- **PEND.**
  - If `cpu_w` = 0: the loader is granted this cycle. `load_idx` increments. Next state is DONE if the new idx = BASE+COUNT, otherwise IDLE.
  - If `cpu_w` = 1: the CPU is granted and `wait_cnt` increments. When `wait_cnt` reaches MAXWAIT-1 while losing, next state is FORCE.
- **FORCE.**
  - `cpu_stall` = 1 and the loader is granted unconditionally. The CPU write is not performed; the CPU re-presents it next cycle.
  - `load_idx` increments, then go to IDLE or DONE as in PEND.
- **DONE.**
  - `load_done` = 1. Strobes are ignored and do not set `overrun`.
- **Restart.** Valid in any state, and wins over a simultaneous strobe or grant that cycle; no loader write occurs.
  - `load_idx` ← BASE, `overrun` ← 0, `wait_cnt` ← 0, go to IDLE. `pend_data` is discarded.
- **Overrun.** A strobe in PEND or FORCE sets `overrun` and is dropped. The pending value is unchanged.
- **Write-port mux** (combinational from state and CPU inputs):
  - Loader granted: `rf_w` = 1, `rf_waddr` = `load_idx`, `rf_wdata` = `pend_data`.
  - Otherwise: the CPU signals pass through. `rf_w` = `cpu_w`, even when `cpu_waddr` = 0; `regs` reads %0 as zero.
- **Output encoding.** `cpu_stall` and `load_done` decode from `state` only, with no combinational path from SW.
- **Shared write port.** `regs` keeps exactly one write port, driven by this block.

## Timing
- **Reset.** With `nReset` = 0 at a rising edge:
  - state IDLE, `load_idx` = BASE, `pend_data` = 0, `wait_cnt` = 0, `overrun` = 0, sync flops = 0.
  - `cpu_stall`, `load_done` = 0.
  - `rf_*` follow `cpu_*` (pass-through).
- **Reset mid-operation.** Any pending loader write is lost. Reset while in FORCE drops `cpu_stall` in the reset cycle's successor.
- **Strobe latency.**
  - SW[8] rises before edge k: s1 at k, s2 at k+1, strobe detected during cycle k+1, PEND from edge k+2.
  - With `cpu_w` = 0 in cycle k+2, `rf_w` = 1 in cycle k+2 and the register updates at edge k+3.
- **Wait bound.** Worst-case loader wait is MAXWAIT cycles in PEND plus 1 forced cycle. `cpu_stall` is high for exactly one cycle per forced write.
- **Throughput.** At most one loader write per 2 cycles (IDLE↔PEND). A physical switch press is far slower.
- **Wrap-around.** None. After COUNT writes the block stays in DONE until restart or reset.

## Structure
- Package `picomips_pkg`:
  - `typedef logic [4:0] regaddr_t`.
  - `typedef enum logic [1:0] {IDLE, PEND, FORCE, DONE} ldstate_t`.
  - SW bit-index constants: SW_LOAD = 8, SW_RESTART = 9.
- Sub-module `sw_sync` (parameterised width): the 3-flop synchroniser plus rising-edge detect, reusable for other switch inputs.
- The FSM and mux remain in `regfile_load_arbiter`.

## Test plan
- **Reset then single strobe, no CPU traffic.** SW[7:0] = 0x5A, raise SW[8].
  - `rf_w` = 1, `rf_waddr` = 1, `rf_wdata` = 0x5A, 2 cycles after the strobe reaches s2.
  - `load_idx` = 2.
- **Contention.** Strobe with `cpu_w` held 1 (addr 7, data 0x33).
  - CPU granted 4 cycles, then FORCE.
  - `cpu_stall` = 1 for one cycle and the loader write goes to reg 1.
  - The CPU write to reg 7 completes the following cycle.
- **Full sequence.** Nine strobes, values 1..9.
  - Regs 1..9 hold 1..9 and `load_done` = 1.
  - A tenth strobe produces no `rf_w` and `overrun` stays 0.
- **Overrun.** Second strobe while in PEND under CPU contention.
  - `overrun` = 1.
  - Only the first value is written.
- **Restart mid-sequence** after 3 loads.
  - `load_idx` = 1, `overrun` = 0.
  - The next strobe value lands in reg 1.
- **Restart and strobe in the same cycle.**
  - No write occurs, state is IDLE, `load_idx` = BASE.
